// File: rtl/muldiv_wb_queue_if.sv
// ---------------------------------------------------------------------------
// muldiv_wb_queue_if
//   Bundle between the multiply/divide unit, the write-back queue and the CDB
//   arbiter.
//   Parameters: DEPTH (queue entries), ROB_IDX_WIDTH (ROB tag width).
//   Signals:
//     flush         pipeline flush towards the queue
//     in_res[1:0]   completed results, [0]=mul, [1]=div (valid on result_ready)
//     cdb_valid     head entry presented to the CDB
//     cdb_result    head result value (0 when cdb_valid=0)
//     cdb_rob_index head ROB tag (0 when cdb_valid=0)
//     cdb_grant     arbiter accepts the presented entry
//     issue_stall   reservation station must not issue
//     count         current occupancy
//     overflow_err  sticky drop indicator
//   Modports: master = producer/arbiter side, slave = the queue.
// ---------------------------------------------------------------------------
interface muldiv_wb_queue_if #(
  parameter int DEPTH         = 8,
  parameter int ROB_IDX_WIDTH = 4
);
  typedef struct packed {
    logic                     result_ready;
    logic [31:0]              result;
    logic [ROB_IDX_WIDTH-1:0] rob_index;
  } alu_result_t;

  logic                         flush;
  alu_result_t [1:0]            in_res;
  logic                         cdb_valid;
  logic [31:0]                  cdb_result;
  logic [ROB_IDX_WIDTH-1:0]     cdb_rob_index;
  logic                         cdb_grant;
  logic                         issue_stall;
  logic [$clog2(DEPTH+1)-1:0]   count;
  logic                         overflow_err;

  modport master (
    output flush, in_res, cdb_grant,
    input  cdb_valid, cdb_result, cdb_rob_index, issue_stall, count, overflow_err
  );

  modport slave (
    input  flush, in_res, cdb_grant,
    output cdb_valid, cdb_result, cdb_rob_index, issue_stall, count, overflow_err
  );
endinterface

// File: rtl/muldiv_wb_queue.sv
// ---------------------------------------------------------------------------
// muldiv_wb_queue
//   In-order write-back queue between the mul/div execution unit and the CDB.
//   Accepts up to two results per cycle (slot 0 older than slot 1), presents
//   one per cycle under a valid/grant handshake, raises issue_stall when free
//   space is below STALL_THRESH, and flags dropped inputs in a sticky
//   overflow_err.
//   Ports:
//     clk  - clock, all state on posedge
//     rst  - synchronous active-high reset (priority over flush)
//     bus  - muldiv_wb_queue_if.slave (flush, in_res, cdb_*, issue_stall,
//            count, overflow_err)
//   Optional feature: define MULDIV_WBQ_BYPASS_EN to let the oldest valid
//   input drive the CDB combinationally when the queue is empty.
// ---------------------------------------------------------------------------
module muldiv_wb_queue #(
  parameter int DEPTH         = 8,
  parameter int ROB_IDX_WIDTH = 4,
  parameter int STALL_THRESH  = 6
) (
  input logic              clk,
  input logic              rst,
  muldiv_wb_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(DEPTH);
  // (DEPTH - count) < STALL_THRESH  <=>  count > DEPTH - STALL_THRESH
  localparam logic [CNT_W-1:0] STALL_LIMIT = CNT_W'(DEPTH - STALL_THRESH);

  logic [31:0]              res_mem [DEPTH];
  logic [ROB_IDX_WIDTH-1:0] tag_mem [DEPTH];

  logic [PTR_W-1:0] head_reg, tail_reg;
  logic [CNT_W-1:0] count_reg;
  logic             overflow_reg;

  logic v0, v1;
  assign v0 = bus.in_res[0].result_ready;
  assign v1 = bus.in_res[1].result_ready;

  logic fifo_valid, deq;
  assign fifo_valid = (count_reg != '0);
  assign deq        = fifo_valid && bus.cdb_grant && !bus.flush;

  logic                     byp_active, byp_take0, byp_take1;
  logic [31:0]              byp_result;
  logic [ROB_IDX_WIDTH-1:0] byp_tag;
`ifdef MULDIV_WBQ_BYPASS_EN
  // Reset is excluded so the CDB stays quiet while rst is held.
  assign byp_active = !fifo_valid && !bus.flush && !rst && (v0 || v1);
  assign byp_take0  = byp_active && bus.cdb_grant && v0;
  assign byp_take1  = byp_active && bus.cdb_grant && !v0;
  assign byp_result = v0 ? bus.in_res[0].result    : bus.in_res[1].result;
  assign byp_tag    = v0 ? bus.in_res[0].rob_index : bus.in_res[1].rob_index;
`else
  assign byp_active = 1'b0;
  assign byp_take0  = 1'b0;
  assign byp_take1  = 1'b0;
  assign byp_result = '0;
  assign byp_tag    = '0;
`endif

  // Inputs still needing storage after any bypass consumption. They are
  // compacted so the older one always lands at tail.
  logic                     w0, w1, has_first, has_second;
  logic [31:0]              first_result;
  logic [ROB_IDX_WIDTH-1:0] first_tag;
  assign w0           = v0 && !byp_take0;
  assign w1           = v1 && !byp_take1;
  assign has_first    = w0 || w1;
  assign has_second   = w0 && w1;
  assign first_result = w0 ? bus.in_res[0].result    : bus.in_res[1].result;
  assign first_tag    = w0 ? bus.in_res[0].rob_index : bus.in_res[1].rob_index;

  // Space seen by the enqueue side includes the slot freed by this cycle's dequeue.
  logic [CNT_W-1:0] room, n_wr;
  logic             wr_first, wr_second, drop;
  assign room      = DEPTH_C - (count_reg - CNT_W'(deq));
  assign wr_first  = has_first && (room != '0);
  assign wr_second = has_second && (room >= CNT_W'(2));
  assign drop      = (has_first && !wr_first) || (has_second && !wr_second);
  assign n_wr      = CNT_W'(wr_first) + CNT_W'(wr_second);

  logic [PTR_W-1:0] tail_plus1;
  assign tail_plus1 = tail_reg + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else if (bus.flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (deq) head_reg <= head_reg + PTR_W'(1);
      tail_reg  <= tail_reg + PTR_W'(n_wr);
      count_reg <= count_reg - CNT_W'(deq) + n_wr;
      if (drop) overflow_reg <= 1'b1;
    end
  end

  // Storage has no reset; only entries between head and tail are ever read.
  always_ff @(posedge clk) begin
    if (!rst && !bus.flush) begin
      if (wr_first) begin
        res_mem[tail_reg] <= first_result;
        tag_mem[tail_reg] <= first_tag;
      end
      if (wr_second) begin
        res_mem[tail_plus1] <= bus.in_res[1].result;
        tag_mem[tail_plus1] <= bus.in_res[1].rob_index;
      end
    end
  end

  always_comb begin
    bus.cdb_valid     = fifo_valid || byp_active;
    bus.cdb_result    = '0;
    bus.cdb_rob_index = '0;
    if (fifo_valid) begin
      bus.cdb_result    = res_mem[head_reg];
      bus.cdb_rob_index = tag_mem[head_reg];
    end else if (byp_active) begin
      bus.cdb_result    = byp_result;
      bus.cdb_rob_index = byp_tag;
    end
  end

  assign bus.issue_stall  = (count_reg > STALL_LIMIT);
  assign bus.count        = count_reg;
  assign bus.overflow_err = overflow_reg;
endmodule
